// File: rtl/fare_pkg.sv
// ---------------------------------------------------------------------------
// fare_pkg
// Shared types and constants for the fare card responder slice.
//   state_t     : responder FSM states (IDLE, LOOKUP, RESPOND)
//   admin_op_t  : admin command encoding (top-up, activate, deactivate, no-op)
//   FARE_CENTS / INIT_BAL_CENTS : default fare and power-up balance
//   cnt_width() : width of a down/up counter that must hold 0..max_val-1
// ---------------------------------------------------------------------------
package fare_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOOKUP  = 2'd1,
      RESPOND = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      ADM_TOPUP = 2'b00,
      ADM_ACT   = 2'b01,
      ADM_DEACT = 2'b10,
      ADM_NOP   = 2'b11
   } admin_op_t;

   localparam int FARE_CENTS     = 275;
   localparam int INIT_BAL_CENTS = 1000;

   // A counter that only ever holds values 0..max_val-1 needs clog2(max_val)
   // bits, but never less than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val > 1) ? $clog2(max_val) : 1;
   endfunction

endpackage

// File: rtl/fare_card_responder_if.sv
// ---------------------------------------------------------------------------
// fare_card_responder_if
// Bundles the gate-side tap/response handshake and the admin command port
// of the fare card responder.
//   master : gate FSM / admin side (drives nfc, card_id, reduce_bal, admin_*)
//   slave  : responder side (drives card_active, fund_enough, resp_valid, busy)
// Parameters ID_W and BAL_W must match the responder's card count and
// balance width.
// ---------------------------------------------------------------------------
interface fare_card_responder_if #(
   parameter int ID_W  = 2,
   parameter int BAL_W = 16
);

   logic             nfc;
   logic [ID_W-1:0]  card_id;
   logic             card_active;
   logic             fund_enough;
   logic             resp_valid;
   logic             reduce_bal;
   logic             admin_valid;
   logic [1:0]       admin_op;
   logic [ID_W-1:0]  admin_id;
   logic [BAL_W-1:0] admin_amt;
   logic             busy;

   modport master (
      output nfc, card_id, reduce_bal,
      output admin_valid, admin_op, admin_id, admin_amt,
      input  card_active, fund_enough, resp_valid, busy
   );

   modport slave (
      input  nfc, card_id, reduce_bal,
      input  admin_valid, admin_op, admin_id, admin_amt,
      output card_active, fund_enough, resp_valid, busy
   );

endinterface

// File: rtl/fare_card_table.sv
// ---------------------------------------------------------------------------
// fare_card_table
// Per-card account storage: one active bit and one unsigned balance per card.
//   clk, rst_n     : clock and async active-low reset (all cards active,
//                    every balance = INIT_BAL)
//   rd_id          : card looked up by the responder FSM
//   rd_active      : active bit of rd_id
//   rd_fund_ok     : balance of rd_id >= FARE
//   debit_en/_id   : subtract FARE from debit_id at the next edge
//   admin_*        : top-up / activate / deactivate / no-op command
// A debit and a top-up hitting the same card in one cycle are merged into a
// single saturating update: bal - FARE + amt, clipped at 2^BAL_W-1.
// ---------------------------------------------------------------------------
module fare_card_table
   import fare_pkg::*;
#(
   parameter int NUM_CARDS = 4,
   parameter int BAL_W     = 16,
   parameter int FARE      = FARE_CENTS,
   parameter int INIT_BAL  = INIT_BAL_CENTS,
   parameter int ID_W      = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [ID_W-1:0]  rd_id,
   output logic             rd_active,
   output logic             rd_fund_ok,
   input  logic             debit_en,
   input  logic [ID_W-1:0]  debit_id,
   input  logic             admin_valid,
   input  admin_op_t        admin_op,
   input  logic [ID_W-1:0]  admin_id,
   input  logic [BAL_W-1:0] admin_amt
);

   localparam int BW1 = BAL_W + 1;
   localparam logic [BAL_W:0]   FARE_EXT = BW1'(FARE);
   localparam logic [BAL_W-1:0] FARE_BAL = BAL_W'(FARE);

   logic             active_q [NUM_CARDS];
   logic             active_d [NUM_CARDS];
   logic [BAL_W-1:0] bal_q    [NUM_CARDS];
   logic [BAL_W-1:0] bal_d    [NUM_CARDS];
   logic [BAL_W:0]   sum      [NUM_CARDS];
   logic [BAL_W-1:0] rd_bal;

   // Read mux. Ids beyond NUM_CARDS read as an inactive, empty card.
   always_comb begin
      rd_active = 1'b0;
      rd_bal    = '0;
      for (int i = 0; i < NUM_CARDS; i++) begin
         if (rd_id == ID_W'(i)) begin
            rd_active = active_q[i];
            rd_bal    = bal_q[i];
         end
      end
      rd_fund_ok = (rd_bal >= FARE_BAL);
   end

   // Next-state arithmetic. The sum is one bit wider than a balance so the
   // top-up overflow shows up as the carry bit and can be clipped. The debit
   // never underflows because the FSM only debits after seeing
   // balance >= FARE, and nothing but debits lowers a balance.
   always_comb begin
      for (int i = 0; i < NUM_CARDS; i++) begin
         active_d[i] = active_q[i];
         sum[i]      = {1'b0, bal_q[i]};
         if (debit_en && (debit_id == ID_W'(i))) begin
            sum[i] = sum[i] - FARE_EXT;
         end
         if (admin_valid && (admin_id == ID_W'(i))) begin
            case (admin_op)
               ADM_TOPUP: sum[i]      = sum[i] + {1'b0, admin_amt};
               ADM_ACT:   active_d[i] = 1'b1;
               ADM_DEACT: active_d[i] = 1'b0;
               default:   ;
            endcase
         end
         bal_d[i] = sum[i][BAL_W] ? {BAL_W{1'b1}} : sum[i][BAL_W-1:0];
      end
   end

   // Account registers; reset re-enables every card with a fresh balance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CARDS; i++) begin
            active_q[i] <= 1'b1;
            bal_q[i]    <= BAL_W'(INIT_BAL);
         end
      end else begin
         for (int i = 0; i < NUM_CARDS; i++) begin
            active_q[i] <= active_d[i];
            bal_q[i]    <= bal_d[i];
         end
      end
   end

endmodule

// File: rtl/fare_card_responder.sv
// ---------------------------------------------------------------------------
// fare_card_responder
// Card-side responder for the SkyTrain gate FSM. A rising edge on nfc starts
// a transaction: the card id is latched, the account is looked up after
// LOOKUP_LAT cycles and card_active / fund_enough are returned with a
// one-cycle resp_valid pulse. For DEBIT_TIMEOUT cycles after that pulse a
// reduce_bal request debits FARE from the card if both flags were set.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   bus (slave)        : nfc, card_id, card_active, fund_enough, resp_valid,
//                        reduce_bal, admin_valid/op/id/amt, busy
//   tap_cnt, deny_cnt  : saturating statistics, only when the macro
//                        FARE_TAP_STATS_EN is defined
// ---------------------------------------------------------------------------
module fare_card_responder
   import fare_pkg::*;
#(
   parameter int NUM_CARDS     = 4,
   parameter int BAL_W         = 16,
   parameter int FARE          = FARE_CENTS,
   parameter int INIT_BAL      = INIT_BAL_CENTS,
   parameter int LOOKUP_LAT    = 2,
   parameter int DEBIT_TIMEOUT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef FARE_TAP_STATS_EN
   output logic [15:0] tap_cnt,
   output logic [15:0] deny_cnt,
`endif
   fare_card_responder_if.slave bus
);

   localparam int ID_W  = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;
   localparam int LAT_W = cnt_width(LOOKUP_LAT);
   localparam int WIN_W = cnt_width(DEBIT_TIMEOUT);

   state_t           state_q, state_d;
   logic             nfc_q, nfc_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   logic             card_active_q, card_active_d;
   logic             fund_enough_q, fund_enough_d;
   logic             resp_valid_q, resp_valid_d;
   logic             debit_en;
   logic             nfc_edge;
   logic             rd_active;
   logic             rd_fund_ok;

   assign nfc_d    = bus.nfc;
   assign nfc_edge = bus.nfc & ~nfc_q;

   fare_card_table #(
      .NUM_CARDS (NUM_CARDS),
      .BAL_W     (BAL_W),
      .FARE      (FARE),
      .INIT_BAL  (INIT_BAL),
      .ID_W      (ID_W)
   ) u_table (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_id       (id_q),
      .rd_active   (rd_active),
      .rd_fund_ok  (rd_fund_ok),
      .debit_en    (debit_en),
      .debit_id    (id_q),
      .admin_valid (bus.admin_valid),
      .admin_op    (admin_op_t'(bus.admin_op)),
      .admin_id    (bus.admin_id),
      .admin_amt   (bus.admin_amt)
   );

   // Next-state / output logic.
   // In RESPOND the cycle carrying resp_valid is not part of the debit
   // window; the window is the DEBIT_TIMEOUT cycles that follow it.
   // The debit is granted from the registered flags, so later admin
   // commands (e.g. a deactivate) cannot revoke it.
   always_comb begin
      state_d       = state_q;
      id_d          = id_q;
      lat_cnt_d     = lat_cnt_q;
      win_cnt_d     = win_cnt_q;
      card_active_d = card_active_q;
      fund_enough_d = fund_enough_q;
      resp_valid_d  = 1'b0;
      debit_en      = 1'b0;
      case (state_q)
         IDLE: begin
            if (nfc_edge) begin
               id_d          = bus.card_id;
               card_active_d = 1'b0;
               fund_enough_d = 1'b0;
               lat_cnt_d     = LAT_W'(LOOKUP_LAT - 1);
               state_d       = LOOKUP;
            end
         end
         LOOKUP: begin
            if (lat_cnt_q == '0) begin
               card_active_d = rd_active;
               fund_enough_d = rd_fund_ok;
               resp_valid_d  = 1'b1;
               win_cnt_d     = '0;
               state_d       = RESPOND;
            end else begin
               lat_cnt_d = lat_cnt_q - 1'b1;
            end
         end
         RESPOND: begin
            if (!resp_valid_q) begin
               if (bus.reduce_bal) begin
                  debit_en = card_active_q & fund_enough_q;
                  state_d  = IDLE;
               end else if (win_cnt_q == WIN_W'(DEBIT_TIMEOUT - 1)) begin
                  state_d = IDLE;
               end else begin
                  win_cnt_d = win_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and response registers. Reset drops any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         nfc_q         <= 1'b0;
         id_q          <= '0;
         lat_cnt_q     <= '0;
         win_cnt_q     <= '0;
         card_active_q <= 1'b0;
         fund_enough_q <= 1'b0;
         resp_valid_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         nfc_q         <= nfc_d;
         id_q          <= id_d;
         lat_cnt_q     <= lat_cnt_d;
         win_cnt_q     <= win_cnt_d;
         card_active_q <= card_active_d;
         fund_enough_q <= fund_enough_d;
         resp_valid_q  <= resp_valid_d;
      end
   end

   assign bus.card_active = card_active_q;
   assign bus.fund_enough = fund_enough_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.busy        = (state_q != IDLE);

`ifdef FARE_TAP_STATS_EN
   logic [15:0] tap_cnt_q, tap_cnt_d;
   logic [15:0] deny_cnt_q, deny_cnt_d;

   // Statistics: taps are counted when accepted, denials when the response
   // is registered; both stick at all-ones instead of wrapping.
   always_comb begin
      tap_cnt_d  = tap_cnt_q;
      deny_cnt_d = deny_cnt_q;
      if ((state_q == IDLE) && nfc_edge && (tap_cnt_q != 16'hFFFF)) begin
         tap_cnt_d = tap_cnt_q + 16'd1;
      end
      if (resp_valid_d && !(card_active_d && fund_enough_d) &&
          (deny_cnt_q != 16'hFFFF)) begin
         deny_cnt_d = deny_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_cnt_q  <= 16'd0;
         deny_cnt_q <= 16'd0;
      end else begin
         tap_cnt_q  <= tap_cnt_d;
         deny_cnt_q <= deny_cnt_d;
      end
   end

   assign tap_cnt  = tap_cnt_q;
   assign deny_cnt = deny_cnt_q;
`endif

endmodule

// File: tb/tb_fare_card_responder.sv
// ---------------------------------------------------------------------------
// tb_fare_card_responder
// Directed scenarios followed by randomized taps/admin commands, checked
// against a card-account model (balance array + active array) in the bench.
// ---------------------------------------------------------------------------
module tb_fare_card_responder;
   import fare_pkg::*;

   localparam int FARE    = 275;
   localparam int INIT    = 1000;
   localparam int WIN     = 4;
   localparam int BAL_MAX = 65535;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   fare_card_responder_if #(.ID_W(2), .BAL_W(16)) bus ();

   fare_card_responder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int cmp_cnt = 0;
   int err_cnt = 0;
   int model_bal [4];
   bit model_act [4];

   // One comparison: count it, and on a difference count and report it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      cmp_cnt++;
      assert (observed === expected)
      else begin
         err_cnt++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         model_bal[i] = INIT;
         model_act[i] = 1'b1;
      end
   endtask

   function automatic int sat_add(input int a, input int b);
      return (a + b > BAL_MAX) ? BAL_MAX : a + b;
   endfunction

   task automatic check_bals(input string tag);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("%s_bal%0d", tag, i), 32'(dut.u_table.bal_q[i]), model_bal[i]);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      checkOutput({tag, "_card_active"}, bus.card_active, 0);
      checkOutput({tag, "_fund_enough"}, bus.fund_enough, 0);
      checkOutput({tag, "_resp_valid"}, bus.resp_valid, 0);
      checkOutput({tag, "_busy"}, bus.busy, 0);
   endtask

   // Standalone admin command, one cycle wide.
   task automatic admin(input int op, input int id, input int amt);
      @(negedge clk);
      bus.admin_valid = 1'b1;
      bus.admin_op    = 2'(op);
      bus.admin_id    = 2'(id);
      bus.admin_amt   = 16'(amt);
      @(negedge clk);
      bus.admin_valid = 1'b0;
      case (op)
         0: model_bal[id] = sat_add(model_bal[id], amt);
         1: model_act[id] = 1'b1;
         2: model_act[id] = 1'b0;
         default: ;
      endcase
   endtask

   // Full tap transaction.
   //   d      : reduce_bal asserted d cycles after the resp_valid cycle
   //   retap  : produce a second nfc rising edge while in LOOKUP
   //   adm_en : same-cycle top-up of this card by adm_amt alongside reduce_bal
   task automatic applyStimulus(input string tag, input int id, input int d,
                                input bit retap, input bit adm_en, input int adm_amt);
      bit exp_ca, exp_fe, in_win;
      int off, exp_idle;
      exp_ca   = model_act[id];
      exp_fe   = (model_bal[id] >= FARE);
      in_win   = (d >= 1) && (d <= WIN);
      exp_idle = in_win ? d + 1 : WIN + 1;

      @(negedge clk);
      bus.nfc     = 1'b1;
      bus.card_id = 2'(id);
      @(negedge clk);
      checkOutput({tag, "_busy"}, bus.busy, 1);
      checkOutput({tag, "_ca_cleared"}, bus.card_active, 0);
      checkOutput({tag, "_fe_cleared"}, bus.fund_enough, 0);
      checkOutput({tag, "_rv_edge1"}, bus.resp_valid, 0);
      if (retap) bus.nfc = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_rv_edge2"}, bus.resp_valid, 0);
      if (retap) bus.nfc = 1'b1;
      @(negedge clk);
      checkOutput({tag, "_rv_edge3"}, bus.resp_valid, 1);
      checkOutput({tag, "_card_active"}, bus.card_active, 32'(exp_ca));
      checkOutput({tag, "_fund_enough"}, bus.fund_enough, 32'(exp_fe));
      bus.nfc = 1'b0;

      off = 0;
      while (off < 12) begin
         bus.reduce_bal = (off == d);
         if ((off == d) && adm_en) begin
            bus.admin_valid = 1'b1;
            bus.admin_op    = 2'b00;
            bus.admin_id    = 2'(id);
            bus.admin_amt   = 16'(adm_amt);
         end
         @(negedge clk);
         off++;
         bus.reduce_bal  = 1'b0;
         bus.admin_valid = 1'b0;
         if (off == 1) checkOutput({tag, "_rv_single"}, bus.resp_valid, 0);
         if (!bus.busy) break;
      end
      checkOutput({tag, "_idle_cycle"}, off, exp_idle);

      // A late request lands in IDLE and must do nothing.
      if (d > WIN) begin
         repeat (d - off) @(negedge clk);
         bus.reduce_bal = 1'b1;
         @(negedge clk);
         bus.reduce_bal = 1'b0;
      end

      if (in_win) begin
         if (exp_ca && exp_fe) model_bal[id] = model_bal[id] - FARE;
         if (adm_en) model_bal[id] = sat_add(model_bal[id], adm_amt);
      end

      checkOutput({tag, "_ca_hold"}, bus.card_active, 32'(exp_ca));
      checkOutput({tag, "_fe_hold"}, bus.fund_enough, 32'(exp_fe));
      check_bals(tag);
   endtask

   initial begin
      int rid, rd, rop, ramt;
      bit radm;
      rst_n           = 1'b0;
      bus.nfc         = 1'b0;
      bus.card_id     = '0;
      bus.reduce_bal  = 1'b0;
      bus.admin_valid = 1'b0;
      bus.admin_op    = 2'b11;
      bus.admin_id    = '0;
      bus.admin_amt   = '0;
      model_reset();

      repeat (2) @(negedge clk);
      check_idle_outputs("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("after_reset");
      check_bals("after_reset");

      $display("[TB] directed: repeated debits on card 0");
      applyStimulus("c0_tap1", 0, 1, 1'b0, 1'b0, 0);
      applyStimulus("c0_tap2", 0, 1, 1'b0, 1'b0, 0);
      applyStimulus("c0_tap3", 0, 1, 1'b0, 1'b0, 0);
      applyStimulus("c0_tap4", 0, 1, 1'b0, 1'b0, 0);

      $display("[TB] directed: deactivated card 1");
      admin(2, 1, 0);
      applyStimulus("c1_deact", 1, 1, 1'b0, 1'b0, 0);

      $display("[TB] directed: saturating top-up and merged debit/top-up");
      admin(0, 2, 65000);
      check_bals("c2_topup");
      applyStimulus("c3_merge", 3, 1, 1'b0, 1'b1, 100);

      $display("[TB] directed: retap in LOOKUP and late reduce_bal");
      applyStimulus("c2_late", 2, 5, 1'b1, 1'b0, 0);
      applyStimulus("c3_lastwin", 3, 4, 1'b0, 1'b0, 0);

      $display("[TB] randomized transactions");
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            rop  = $urandom_range(0, 3);
            ramt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 65535)
                                               : $urandom_range(0, 1500);
            admin(rop, $urandom_range(0, 3), ramt);
         end
         rid  = $urandom_range(0, 3);
         rd   = $urandom_range(1, 6);
         radm = (rd <= WIN) && ($urandom_range(0, 3) == 0);
         ramt = $urandom_range(0, 2000);
         applyStimulus($sformatf("rnd%0d", n), rid, rd, 1'($urandom_range(0, 1)), radm, ramt);
      end

      $display("[TB] directed: reset while in RESPOND");
      @(negedge clk);
      bus.nfc     = 1'b1;
      bus.card_id = 2'd3;
      repeat (3) @(negedge clk);
      checkOutput("rst_mid_rv", bus.resp_valid, 1);
      bus.nfc        = 1'b0;
      bus.reduce_bal = 1'b1;
      rst_n          = 1'b0;
      #1;
      model_reset();
      check_idle_outputs("rst_mid");
      check_bals("rst_mid");
      @(negedge clk);
      bus.reduce_bal = 1'b0;
      rst_n          = 1'b1;
      @(negedge clk);
      check_bals("rst_release");
      applyStimulus("post_reset", 0, 1, 1'b0, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/fare_card_responder.md
Name: fare_card_responder

Overview:
Card-side responder for the SkyTrain gate FSM.
- Consumes the gate-side tap strobe `nfc` and returns `card_active` / `fund_enough` after a fixed lookup latency.
- Applies the fare debit when the gate returns `reduce_bal`.
- Holds a small per-card account table (active bit plus balance) and an admin port for top-up and activation.
- Sits between the NFC reader front end and the gate FSM.

Parameters:
- NUM_CARDS, 4: number of card accounts; ID_W = $clog2(NUM_CARDS).
- BAL_W, 16: balance width in cents, unsigned.
- FARE, 275: fare deducted per accepted entry, in cents.
- INIT_BAL, 1000: balance of every card after reset.
- LOOKUP_LAT, 2: cycles from accepted tap to response, ≥1.
- DEBIT_TIMEOUT, 4: cycles after the response during which `reduce_bal` is honoured.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- nfc  in  1  tap strobe from the gate side; a rising edge starts a transaction.
- card_id  in  ID_W  card presented; sampled on the nfc rising edge.
- card_active  out  1  selected card is enabled; valid from resp_valid.
- fund_enough  out  1  selected balance ≥ FARE; valid from resp_valid.
- resp_valid  out  1  one-cycle pulse; marks card_active/fund_enough as updated.
- reduce_bal  in  1  debit request from the gate FSM.
- admin_valid  in  1  admin command strobe.
- admin_op  in  2  00 top-up, 01 activate, 10 deactivate, 11 no-op.
- admin_id  in  ID_W  target card of the admin command.
- admin_amt  in  BAL_W  top-up amount.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; all outputs 0.
  - every active bit = 1; every balance = INIT_BAL.
  - the nfc edge-detect register is cleared.
  - Reset mid-transaction abandons it; no debit is applied.
- States:
  - IDLE:
    - on an nfc rising edge (nfc=1 and registered nfc_q=0), latch card_id.
    - clear card_active and fund_enough.
    - load lat_cnt = LOOKUP_LAT-1; go to LOOKUP.
  - LOOKUP:
    - decrement lat_cnt.
    - at 0, register active[id] and (bal[id] ≥ FARE).
    - pulse resp_valid for one cycle; go to RESPOND.
    - Total latency: resp_valid is high exactly LOOKUP_LAT+1 cycles after the edge is sampled.
  - RESPOND:
    - window counter runs for DEBIT_TIMEOUT cycles, starting the cycle after resp_valid.
    - reduce_bal=1 in the window with card_active=1 and fund_enough=1: bal[id] -= FARE at the next edge; go to IDLE.
    - reduce_bal=1 while either flag is 0: no debit; go to IDLE.
    - window expiry: go to IDLE with no debit.
- Output holding: card_active and fund_enough hold their values after return to IDLE, until the next accepted tap clears them.
- Ignored inputs:
  - nfc edges while busy=1 are ignored; there is no queueing.
  - reduce_bal in IDLE or LOOKUP is ignored.
- Flag independence: fund_enough is computed regardless of the active bit.
- Arithmetic:
  - a debit cannot underflow (it is guarded by fund_enough).
  - top-up saturates at 2^BAL_W-1.
- Admin commands:
  - accepted in any state; take effect at the next edge.
  - activate/deactivate writes the active bit only.
- Simultaneous debit and top-up on the same card in one cycle: new bal = sat(bal - FARE + admin_amt).
- Admin during an in-flight transaction:
  - a deactivate does not cancel a debit already granted by a registered card_active=1.
  - registered response flags are not re-evaluated.

Optional Feature:
- Macro: FARE_TAP_STATS_EN.
- Defined:
  - adds outputs tap_cnt[15:0] and deny_cnt[15:0].
  - tap_cnt increments per accepted tap.
  - deny_cnt increments per resp_valid with card_active=0 or fund_enough=0.
  - both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; other behaviour is identical.

Decomposition:
- Shared package fare_pkg holds:
  - state_t enum {IDLE, LOOKUP, RESPOND};
  - admin_op_t enum {ADM_TOPUP, ADM_ACT, ADM_DEACT, ADM_NOP};
  - default constants FARE_CENTS=275 and INIT_BAL_CENTS=1000.
- Sub-module fare_card_table holds:
  - storage: active bit and balance arrays;
  - a read port for id;
  - the debit port and admin port, with combined saturating update arithmetic.
- The top level keeps the FSM, the edge detect and the counters.

Test Plan (defaults):
- Tap id0 → resp_valid exactly 3 cycles after the nfc edge, card_active=1, fund_enough=1. reduce_bal 1 cycle later → bal0=725.
- Four taps with debit on id0 → balances 725, 450, 175. Fourth tap gives fund_enough=0; its reduce_bal is ignored; bal0 stays 175.
- Admin deactivate id1, then tap id1 → card_active=0, fund_enough=1. reduce_bal → no debit; bal1=1000.
- Admin top-up id2 by 65000 → bal2=65535 (saturated). Same-cycle debit of id3 plus top-up 100 on id3 → bal3=825.
- Second nfc edge during LOOKUP → ignored, single resp_valid. reduce_bal 5 cycles after resp_valid → ignored, balance unchanged.
- rst_n=0 in RESPOND → all outputs 0 immediately, no debit, balances back to 1000. With FARE_TAP_STATS_EN: tap_cnt/deny_cnt match the accepted and denied counts of the earlier scenarios.
